aes_decrypt_core: RTL and testbench



---
 rtl/aes_pkg.sv | 100 ++++++++++
 rtl/aes_decrypt_core_if.sv | 24 ++
 rtl/aes_inv_round.sv | 52 +++++
 rtl/aes_decrypt_core.sv | 138 +++++++++++++
 tb/tb_aes_decrypt_core.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, FSM state type, round-constant table,
// S-box functions and GF(2^8) helpers (polynomial 0x11b).
package aes_pkg;

  localparam int unsigned NR     = 10;
  localparam int unsigned BlockW = 128;
  localparam int unsigned KeyW   = 128;

  typedef enum logic [1:0] {
    StIdle,
    StKexp,
    StRound,
    StDone
  } aes_fsm_e;

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  // Forward S-box: inversion followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform followed by inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] t;
    t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Round constant table, indexed 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // InvMixColumns matrix row 0; row r is this rotated right by r.
  function automatic logic [7:0] inv_mix_coef(input int unsigned idx);
    logic [7:0] c;
    case (idx)
      0:       c = 8'h0e;
      1:       c = 8'h0b;
      2:       c = 8'h0d;
      default: c = 8'h09;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/aes_decrypt_core_if.sv
// aes_decrypt_core_if: ciphertext/key input stream and plaintext output stream.
interface aes_decrypt_core_if;
  import aes_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BlockW-1:0] in_block;
  logic [KeyW-1:0]   in_key;
  logic              out_valid;
  logic              out_ready;
  logic [BlockW-1:0] out_block;
  logic              busy;

  modport master (
    output in_valid, in_block, in_key, out_ready,
    input  in_ready, out_valid, out_block, busy
  );

  modport slave (
    input  in_valid, in_block, in_key, out_ready,
    output in_ready, out_valid, out_block, busy
  );

endinterface

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round. InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless i_last_round bypasses it.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BlockW-1:0] i_state,
  input  logic [KeyW-1:0]   i_round_key,
  input  logic              i_last_round,
  output logic [BlockW-1:0] o_state
);

  logic [BlockW-1:0] w_shift;
  logic [BlockW-1:0] w_sub;
  logic [BlockW-1:0] w_ark;
  logic [BlockW-1:0] w_mix;

  // InvShiftRows: byte (row r, col c) comes from column (c - r) mod 4.
  always_comb begin
    w_shift = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shift[127-8*(4*c+r) -: 8] = i_state[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
  end

  // InvSubBytes on every byte.
  always_comb begin
    w_sub = '0;
    for (int i = 0; i < 16; i++) begin
      w_sub[127-8*i -: 8] = inv_sbox(w_shift[127-8*i -: 8]);
    end
  end

  assign w_ark = w_sub ^ i_round_key;

  // InvMixColumns, column by column.
  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 4; k++) begin
          w_mix[127-8*(4*c+r) -: 8] = w_mix[127-8*(4*c+r) -: 8] ^
              gmul(w_ark[127-8*(4*c+k) -: 8], inv_mix_coef((k + 4 - r) % 4));
        end
      end
    end
  end

  assign o_state = i_last_round ? w_ark : w_mix;

endmodule

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 inverse cipher, one inverse round per clock,
// round keys derived on the fly with the reverse key schedule.
// Build option AES_DEC_FWDKEY_EN: in_key is the cipher key k0 and a 10-cycle KEXP
// phase runs the forward schedule to reach k10; otherwise in_key is k10 directly.
module aes_decrypt_core
  import aes_pkg::*;
(
  input logic               clk,
  input logic               rst,
  aes_decrypt_core_if.slave bus
);

  aes_fsm_e          r_fsm;
  aes_fsm_e          w_fsm_next;
  logic [BlockW-1:0] r_state;
  logic [BlockW-1:0] w_state_next;
  logic [KeyW-1:0]   r_key;
  logic [KeyW-1:0]   w_key_next;
  logic [3:0]        r_rnd;
  logic [3:0]        w_rnd_next;

  logic [31:0]       w_rev_w0;
  logic [31:0]       w_rev_w1;
  logic [31:0]       w_rev_w2;
  logic [31:0]       w_rev_w3;
  logic [KeyW-1:0]   w_prev_key;
  logic [BlockW-1:0] w_round_out;
  logic              w_last;

  // Reverse schedule: k(r) from k(r+1); word 0 uses the freshly derived word 3.
  always_comb begin
    w_rev_w3   = r_key[31:0] ^ r_key[63:32];
    w_rev_w2   = r_key[63:32] ^ r_key[95:64];
    w_rev_w1   = r_key[95:64] ^ r_key[127:96];
    w_rev_w0   = r_key[127:96] ^ sub_word(rot_word(w_rev_w3)) ^ {rcon(r_rnd + 4'd1), 24'h0};
    w_prev_key = {w_rev_w0, w_rev_w1, w_rev_w2, w_rev_w3};
  end

`ifdef AES_DEC_FWDKEY_EN
  logic [31:0]     w_fwd_w0;
  logic [31:0]     w_fwd_w1;
  logic [31:0]     w_fwd_w2;
  logic [31:0]     w_fwd_w3;
  logic [KeyW-1:0] w_fwd_key;

  // Forward schedule step: k(rnd+1) from k(rnd) while in KEXP.
  always_comb begin
    w_fwd_w0  = r_key[127:96] ^ sub_word(rot_word(r_key[31:0])) ^ {rcon(r_rnd + 4'd1), 24'h0};
    w_fwd_w1  = r_key[95:64] ^ w_fwd_w0;
    w_fwd_w2  = r_key[63:32] ^ w_fwd_w1;
    w_fwd_w3  = r_key[31:0] ^ w_fwd_w2;
    w_fwd_key = {w_fwd_w0, w_fwd_w1, w_fwd_w2, w_fwd_w3};
  end
`endif

  assign w_last = (r_rnd == 4'd0);

  aes_inv_round u_inv_round (
    .i_state      (r_state),
    .i_round_key  (w_prev_key),
    .i_last_round (w_last),
    .o_state      (w_round_out)
  );

  // Next-state, datapath updates and stream handshake outputs.
  always_comb begin
    w_fsm_next    = r_fsm;
    w_state_next  = r_state;
    w_key_next    = r_key;
    w_rnd_next    = r_rnd;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_block = '0;
    bus.busy      = 1'b1;
    unique case (r_fsm)
      StIdle: begin
        bus.busy     = 1'b0;
        bus.in_ready = !rst;
        if (bus.in_valid) begin
`ifdef AES_DEC_FWDKEY_EN
          w_state_next = bus.in_block;
          w_key_next   = bus.in_key;
          w_rnd_next   = 4'd0;
          w_fsm_next   = StKexp;
`else
          w_state_next = bus.in_block ^ bus.in_key;
          w_key_next   = bus.in_key;
          w_rnd_next   = 4'(NR - 1);
          w_fsm_next   = StRound;
`endif
        end
      end
`ifdef AES_DEC_FWDKEY_EN
      StKexp: begin
        w_key_next = w_fwd_key;
        w_rnd_next = r_rnd + 4'd1;
        if (r_rnd == 4'(NR - 1)) begin
          // Whitening with k10 as it is produced.
          w_state_next = r_state ^ w_fwd_key;
          w_rnd_next   = 4'(NR - 1);
          w_fsm_next   = StRound;
        end
      end
`endif
      StRound: begin
        w_key_next   = w_prev_key;
        w_state_next = w_round_out;
        if (w_last) begin
          w_fsm_next = StDone;
        end else begin
          w_rnd_next = r_rnd - 4'd1;
        end
      end
      StDone: begin
        bus.out_valid = 1'b1;
        bus.out_block = r_state;
        if (bus.out_ready) w_fsm_next = StIdle;
      end
      default: w_fsm_next = StIdle;
    endcase
  end

  // State, datapath and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= StIdle;
      r_state <= '0;
      r_key   <= '0;
      r_rnd   <= 4'd0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_state <= w_state_next;
      r_key   <= w_key_next;
      r_rnd   <= w_rnd_next;
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb_aes_decrypt_core: directed FIPS-197 vectors, backpressure, busy-accept,
// mid-block reset and a back-to-back round-trip run against a table-driven
// AES-128 encrypt model, with a per-cycle stream monitor.
module tb_aes_decrypt_core;

`ifdef AES_DEC_FWDKEY_EN
  localparam int LAT = 21;
`else
  localparam int LAT = 11;
`endif

  localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K0_1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KA_1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] P1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K0_2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KA_2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] P2   = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic mon_en = 1'b0;
  logic [127:0] tb_exp;

  typedef struct packed {
    logic [127:0] blk;
    int           t;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0]    sb[256];
  logic [2047:0] sbox_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_decrypt_core_if bus ();

  aes_decrypt_core u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] k0, input int r);
    logic [31:0] w[44];
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      if (i % 4 == 0) begin
        w[i] = w[i-4] ^ subw({w[i-1][23:0], w[i-1][31:24]}) ^ {rc, 24'h0};
        rc   = xt(rc);
      end else begin
        w[i] = w[i-4] ^ w[i-1];
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k0);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ k0[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      rk = round_key(k0, r);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row+4*c] = sb[s[row+4*((c+row)%4)]];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Key the DUT expects for a given cipher key.
  function automatic logic [127:0] dut_key(input logic [127:0] k0);
`ifdef AES_DEC_FWDKEY_EN
    return k0;
`else
    return round_key(k0, 10);
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- per-cycle stream monitor ----------------
  logic m_ready;
  logic m_valid;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        m_ready = !rst && (exp_q.size() == 0);
        m_valid = (exp_q.size() != 0) && (cyc >= exp_q[0].t + LAT);
        check("mon_in_ready", bus.in_ready, m_ready);
        check("mon_busy", bus.busy, exp_q.size() != 0);
        check("mon_out_valid", bus.out_valid, m_valid);
        if (m_valid) check("mon_out_block", bus.out_block, exp_q[0].blk);
        if (rst) begin
          exp_q.delete();
        end else begin
          if (m_valid && bus.out_ready) void'(exp_q.pop_front());
          if (bus.in_valid && m_ready) exp_q.push_back('{tb_exp, cyc});
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send(input logic [127:0] blk, input logic [127:0] key,
                      input logic [127:0] expv, output int t_acc);
    int n;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_block = blk;
    bus.in_key   = key;
    tb_exp       = expv;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    t_acc = cyc;
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Post-accept input changes must not affect the block in flight.
    bus.in_block = rand128();
    bus.in_key   = rand128();
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      n_checks++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", bus.out_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    int t_prev;
    logic [127:0] p;
    logic [127:0] k;
    logic [127:0] c;

    sbox_v = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    for (int i = 0; i < 256; i++) sb[i] = sbox_v[2047-8*i -: 8];

    // Pin the model to FIPS-197 values.
    check("model_enc_c1", encrypt(P1, K0_1), C1);
    check("model_k10_c1", round_key(K0_1, 10), KA_1);
    check("model_enc_b", encrypt(P2, K0_2), C2);
    check("model_k10_b", round_key(K0_2, 10), KA_2);

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_block  = '0;
    bus.in_key    = '0;
    bus.out_ready = 1'b1;
    tb_exp        = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_out_block", bus.out_block, '0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1'b1);

    // FIPS-197 C.1 with exact latency.
    send(C1, dut_key(K0_1), P1, t);
    wait_valid();
    check("c1_latency", cyc - t, LAT);
    check("c1_block", bus.out_block, P1);
    @(posedge clk);
    #1;

    // FIPS-197 B.
    send(C2, dut_key(K0_2), P2, t);
    wait_valid();
    check("b_latency", cyc - t, LAT);
    check("b_block", bus.out_block, P2);
    @(posedge clk);
    #1;

    // Backpressure: output held while out_ready is low.
    bus.out_ready = 1'b0;
    send(C1, dut_key(K0_1), P1, t);
    wait_valid();
    repeat (20) @(negedge clk);
    check("bp_hold_block", bus.out_block, P1);
    check("bp_hold_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_in_ready_after", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;

    // in_valid toggled with junk while busy: ignored.
    send(C2, dut_key(K0_2), P2, t);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (i % 2 == 0);
      bus.in_block = rand128();
      bus.in_key   = rand128();
      tb_exp       = rand128();
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid();
    check("busy_block", bus.out_block, P2);
    @(posedge clk);
    #1;
    repeat (15) @(negedge clk);

    // Reset mid-block discards it; next block decrypts normally.
    send(C1, dut_key(K0_1), P1, t);
    while (cyc < t + 5) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_idle", bus.in_ready, 1'b1);
    repeat (25) @(negedge clk);
    send(C2, dut_key(K0_2), P2, t);
    wait_valid();
    check("post_rst_latency", cyc - t, LAT);
    check("post_rst_block", bus.out_block, P2);
    @(posedge clk);
    #1;

    // Back-to-back random round-trip blocks.
    t_prev = 0;
    for (int i = 0; i < 100; i++) begin
      p = rand128();
      k = rand128();
      c = encrypt(p, k);
      send(c, dut_key(k), p, t);
      if (i > 0) check("b2b_spacing", t - t_prev, LAT + 1);
      t_prev = t;
    end
    wait_valid();
    @(posedge clk);
    #1;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
